// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time,
// handles branch/jump redirects and delivers instructions to decode over valid/ready.
module instr_fetch_unit #(
  parameter int unsigned             WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0]    RESET_PC  = '0,
  parameter int unsigned             PC_STEP   = 4,
  parameter int unsigned             CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WORD_SIZE-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [WORD_SIZE-1:0] imem_rsp_data,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_instr,
  output logic [WORD_SIZE-1:0] out_pc,
  output logic [WORD_SIZE-1:0] prog_count,
  output logic [CNT_WIDTH-1:0] fetch_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_SIZE-1:0]   pc_q, pc_d;
  logic                   drop_q, drop_d;
  logic [WORD_SIZE-1:0]   instr_q, instr_d;
  logic [WORD_SIZE-1:0]   opc_q, opc_d;
  logic                   req_valid_q, out_valid_q;
  logic [CNT_WIDTH-1:0]   fetch_q, stall_q;
  logic                   fetch_inc, stall_inc;

  // State, PC and output registers; handshake flags are registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      instr_q     <= '0;
      opc_q       <= '0;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      instr_q     <= instr_d;
      opc_q       <= opc_d;
      req_valid_q <= (state_d == ST_REQ);
      out_valid_q <= (state_d == ST_HOLD);
    end
  end

  // Next-state logic; drop marks an in-flight response that a redirect made stale.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    instr_d   = instr_q;
    opc_d     = opc_q;
    fetch_inc = 1'b0;
    stall_inc = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_req_ready) begin
          state_d = ST_WAIT;
          if (redirect_valid) begin
            drop_d = 1'b1;
            pc_d   = redirect_pc;
          end
        end else begin
          stall_inc = 1'b1;
          if (redirect_valid) pc_d = redirect_pc;
        end
      end
      ST_WAIT: begin
        stall_inc = 1'b1;
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            instr_d = imem_rsp_data;
            opc_d   = pc_q;
            pc_d    = pc_q + WORD_SIZE'(PC_STEP);
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          fetch_inc = 1'b1;
          state_d   = ST_REQ;
        end else begin
          stall_inc = 1'b1;
        end
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      if (fetch_inc && (fetch_q != '1)) fetch_q <= fetch_q + CNT_WIDTH'(1);
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign prog_count     = pc_q;
  assign out_valid      = out_valid_q;
  assign out_instr      = instr_q;
  assign out_pc         = opc_q;
  assign fetch_count    = fetch_q;
  assign stall_count    = stall_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a latency-varying memory model drives the DUT and
// a scoreboard checks the delivered instruction stream and counters against a stream model.
module tb_instr_fetch_unit;

  localparam int unsigned W   = 32;
  localparam int unsigned CW  = 8;
  localparam logic [W-1:0] RPC = 32'hFFFF_FFF0;
  localparam int          CMAX = 255;

  logic          clk;
  logic          rst;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [W-1:0]  imem_req_addr;
  logic          imem_rsp_valid;
  logic [W-1:0]  imem_rsp_data;
  logic          redirect_valid;
  logic [W-1:0]  redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_instr;
  logic [W-1:0]  out_pc;
  logic [W-1:0]  prog_count;
  logic [CW-1:0] fetch_count;
  logic [CW-1:0] stall_count;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(
    .WORD_SIZE(W), .RESET_PC(RPC), .PC_STEP(4), .CNT_WIDTH(CW)
  ) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .prog_count(prog_count),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_req_addr"},  imem_req_addr, RPC);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_instr"}, out_instr, 32'd0);
    check({tag, "_out_pc"},    out_pc, 32'd0);
    check({tag, "_prog_count"}, prog_count, RPC);
    check({tag, "_fetch_cnt"}, 32'(fetch_count), 32'd0);
    check({tag, "_stall_cnt"}, 32'(stall_count), 32'd0);
  endtask

  // Scoreboard/monitor: the expected stream is sequential PCs, restarted at each redirect target.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  logic [W-1:0] held_pc, held_instr;
  int           fetch_m, stall_m, since;
  bit           started, hold_chk;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_q.push_back(RPC);
      fetch_m  = 0;
      stall_m  = 0;
      started  = 1'b0;
      hold_chk = 1'b0;
      check_reset_outputs("rst");
    end else begin
      check("addr_eq_pc", imem_req_addr, prog_count);
      check("fetch_count", 32'(fetch_count), 32'(fetch_m));
      check("stall_count", 32'(stall_count), 32'(stall_m));
      if (!started) begin
        check("idle_req_valid", 32'(imem_req_valid), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        started = 1'b1;
        since   = 0;
      end else begin
        since++;
        if (since == 1) begin
          check("first_req_valid", 32'(imem_req_valid), 32'd1);
          check("first_req_addr", imem_req_addr, RPC);
        end
        if (hold_chk && out_valid) begin
          check("hold_pc_stable", out_pc, held_pc);
          check("hold_instr_stable", out_instr, held_instr);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deliver_unexpected: actual=%0h required=none", out_pc);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", out_pc, e);
            check("out_instr", out_instr, mem_word(e));
            exp_q.push_back(e + 32'd4);
          end
          if (fetch_m < CMAX) fetch_m++;
        end
        if (!(imem_req_valid && imem_req_ready) && !(out_valid && out_ready) && stall_m < CMAX)
          stall_m++;
        hold_chk   = out_valid && !out_ready;
        held_pc    = out_pc;
        held_instr = out_instr;
        if (redirect_valid) begin
          exp_q.delete();
          exp_q.push_back(redirect_pc);
        end
      end
    end
  end

  // Memory model and random stimulus.
  bit           acc, pend;
  logic [W-1:0] acc_addr, pend_addr;
  int           lat;

  task automatic run_cycle(input bit allow_redir);
    @(negedge clk);
    acc      = rst && imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    @(posedge clk);
    #1;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = acc_addr;
      lat       = (($urandom % 8) == 0) ? 5 : int'($urandom_range(0, 2));
    end
    if (pend && lat == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr);
      pend           = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (pend) lat--;
    end
    imem_req_ready = ($urandom % 3) != 0;
    out_ready      = ($urandom % 4) != 0;
    redirect_valid = allow_redir && (($urandom % 12) == 0);
    redirect_pc    = (($urandom % 4) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_FFFC);
  endtask

  bit found;

  initial begin
    rst = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    pend = 1'b0;
    lat  = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    repeat (40) run_cycle(1'b0);
    repeat (2500) run_cycle(1'b1);

    // Drive into WAIT with a pending response, then reset asynchronously.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      run_cycle(1'b0);
      found = pend && !imem_req_valid;
    end
    check("reach_wait", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    pend = 1'b0;
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1 imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 rst = 1'b1;

    repeat (40) run_cycle(1'b0);
    repeat (500) run_cycle(1'b1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
